// File: rtl/shift_deserializer.sv
// shift_deserializer: collects FROM/TO narrow beats (MSB chunk first) into one
// FROM-bit word and holds it behind a valid/ready handshake.

// One TO-bit slice of the partial-word accumulator.
module shift_deserializer_lane #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear wins over load so a completing beat leaves the slice empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      q <= '0;
    else if (clear) q <= '0;
    else if (load)  q <= d;
  end

endmodule

module shift_deserializer #(
  parameter int FROM     = 32,
  parameter int LOG2FROM = 5,
  parameter int TO       = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [TO-1:0]   data_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            flush_i,
  output logic [FROM-1:0] data_o,
  output logic            valid_o,
  input  logic            ready_i
);

  // FROM must be a multiple of TO with at least two beats per word.
  localparam int R  = FROM / TO;
  localparam int CW = LOG2FROM + 1;
  localparam logic [CW-1:0] LAST = CW'(R - 1);

  logic [CW-1:0]            cnt;
  // Only R-1 slices are stored: the final beat goes straight to data_o.
  logic [R-2:0][TO-1:0]     acc;
  logic [R-1:0][TO-1:0]     shifted;
  logic                     last, accept, complete;

  assign last     = (cnt == LAST);
  // Only the completing beat stalls, and only while the held word is unread.
  assign ready_o  = !(last && valid_o && !ready_i);
  assign accept   = valid_i && ready_o && !flush_i;
  assign complete = accept && last;
  // Older beats move one slice up; the new beat enters at the LSBs.
  assign shifted  = {acc, data_i};

  genvar j;
  generate
    for (j = 0; j < R - 1; j++) begin : g_lane
      shift_deserializer_lane #(.W(TO)) u_lane (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .clear (flush_i || complete),
        .d     (shifted[j]),
        .q     (acc[j])
      );
    end
  endgenerate

  // Beat counter: wraps on completion, zeroed by flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        cnt <= '0;
    else if (flush_i) cnt <= '0;
    else if (accept)  cnt <= last ? '0 : cnt + CW'(1);
  end

  // Output register: new word on completion, otherwise drop valid once consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if (complete) begin
      data_o  <= shifted;
      valid_o <= 1'b1;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule
